em_pipe_reg: RTL and testbench
==============================

Name: em_pipe_reg

Overview:
- E→M pipeline register directly downstream of the E-stage ALU.
- Captures ALU result, overflow flag, store data, destination register and control. Derives the E-stage exception code (Ov, AdEL, AdES) from ALU overflow and load/store address alignment.
- Supports stall (hold), bubble insertion (flush) and exception-request clear driven by CP0.

Parameters:
- EXC_ENTRY, 32'h0000_4180, PC loaded into M_PC on exception-request clear.
- DM_END, 32'h0000_2FFF, last valid data-memory byte address (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- en  in  1  1 = load E values; 0 = hold (stall)
- flush  in  1  insert bubble on next edge
- Req  in  1  CP0 exception/interrupt request; clears register to entry state
- E_PC  in  32  PC of instruction in E
- E_Instr  in  32  instruction word
- E_ALURes  in  32  ALU result; also the load/store address; may be high-Z when E_Overflow=1
- E_Overflow  in  1  ALU signed overflow
- E_WriteData  in  32  forwarded rt value for stores
- E_RegAddr  in  5  destination GPR (0 = none)
- E_BD  in  1  instruction is in a branch delay slot
- E_ExcCode  in  5  exception already raised upstream (0 = none)
- E_OvCheck  in  1  instruction traps on overflow (add, addi, sub)
- E_MemOp  in  4  0 none, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 SW, 7 SH, 8 SB
- M_PC, M_Instr, M_ALURes, M_WriteData  out  32 each  registered copies
- M_RegAddr  out  5  registered destination
- M_BD  out  1  registered delay-slot flag
- M_MemOp  out  4  registered memory op
- M_ExcCode  out  5  final exception code (0 none, 4 AdEL, 5 AdES, 12 Ov, other codes passed through)

Behaviour:
- All updates occur on the rising edge of clk. Priority: reset > Req > flush > !en > load.
- reset: every output is 0, except M_PC = 0x0000_3000.
- Req: every output is 0, except M_PC = EXC_ENTRY.
- flush: every output is 0, except M_PC = E_PC and M_BD = E_BD. The bubble keeps the PC and BD flag so that EPC stays correct.
- !en: all outputs hold.
- load: outputs take E values, with these rules:
  - M_ALURes = 0 when E_Overflow=1. High-Z must never be registered.
  - M_RegAddr is forced to 0 when the computed exception code is nonzero.
  - M_MemOp is forced to 0 when the computed exception code is nonzero, so a faulting store never writes memory.
- Exception derivation is combinational on E inputs and registered into M_ExcCode. Priority order:
  1. E_ExcCode ≠ 0 → pass through unchanged.
  2. E_OvCheck & E_Overflow → 12.
  3. Load op (1–5) & E_Overflow → 4; store op (6–8) & E_Overflow → 5.
  4. LW with addr[1:0] ≠ 0, or LH/LHU with addr[0] = 1 → 4.
  5. SW with addr[1:0] ≠ 0, or SH with addr[0] = 1 → 5.
  6. Otherwise → 0.
- Alignment checks are evaluated only when E_Overflow=0. LB, LBU and SB never misalign.
- E_Overflow with E_MemOp=0 and E_OvCheck=0 (e.g. addiu-style use) raises no exception; M_ALURes = 0 in that case.
- Latency: exactly 1 cycle from E inputs to M outputs.
- Simultaneous flush and en=0: flush wins (a bubble is inserted).
- Reset asserted mid-stall: the register clears regardless of en.

Optional Feature:
- Macro: EM_ADDR_RANGE_CHK_EN.
- When defined, after the alignment checks (same priority tier), only these addresses are legal for loads/stores:
  - 0..DM_END
  - 0x7F00–0x7F0B (timer 0)
  - 0x7F10–0x7F1B (timer 1)
  - 0x7F20–0x7F23 (interrupt generator)
- Illegal address → 4 for loads, 5 for stores.
- Additional faults:
  - Non-word access (LH, LHU, LB, LBU, SH, SB) to any timer address → 4 for loads, 5 for stores.
  - Store to a timer count register (0x7F08–0x7F0B, 0x7F18–0x7F1B) → 5.
- When not defined: no range checks; only the overflow and alignment checks apply.

Test Plan:
- Load path: E_MemOp=LW, E_ALURes=0x0000_0104, no overflow, en=1 → next cycle M_ALURes=0x104, M_ExcCode=0, M_RegAddr=E_RegAddr.
- Overflow trap: E_OvCheck=1, E_Overflow=1, E_ALURes=Z, E_RegAddr=8 → M_ExcCode=12, M_ALURes=0, M_RegAddr=0.
- Misaligned store: SH, E_ALURes=0x0000_0003 → M_ExcCode=5, M_MemOp=0. Same address with SB → M_ExcCode=0, M_MemOp=8.
- Stall then flush: en=0 for 2 cycles → outputs hold. Then flush=1 with E_PC=0x3010, E_BD=1 → M_Instr=0, M_PC=0x3010, M_BD=1.
- Req beats flush: Req=1 and flush=1 together → M_PC=0x4180, all other outputs 0. With EM_ADDR_RANGE_CHK_EN: LW at 0x7F08 → M_ExcCode=0; SW at 0x7F08 → 5; LW at 0x0000_3000 → 4.

Source files
------------

// File: rtl/em_pipe_reg.sv
// E->M pipeline register: latches the E-stage ALU outputs and control, and derives the E-stage exception code.
// Optional macro EM_ADDR_RANGE_CHK_EN adds data-memory / MMIO address-range checks for loads and stores.
module em_pipe_reg #(
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] DM_END    = 32'h0000_2FFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        flush,
    input  logic        Req,
    input  logic [31:0] E_PC,
    input  logic [31:0] E_Instr,
    input  logic [31:0] E_ALURes,
    input  logic        E_Overflow,
    input  logic [31:0] E_WriteData,
    input  logic [4:0]  E_RegAddr,
    input  logic        E_BD,
    input  logic [4:0]  E_ExcCode,
    input  logic        E_OvCheck,
    input  logic [3:0]  E_MemOp,
    output logic [31:0] M_PC,
    output logic [31:0] M_Instr,
    output logic [31:0] M_ALURes,
    output logic [31:0] M_WriteData,
    output logic [4:0]  M_RegAddr,
    output logic        M_BD,
    output logic [3:0]  M_MemOp,
    output logic [4:0]  M_ExcCode
);

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [4:0]  EXC_ADEL = 5'd4;
    localparam logic [4:0]  EXC_ADES = 5'd5;
    localparam logic [4:0]  EXC_OV   = 5'd12;

    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;

`ifdef EM_ADDR_RANGE_CHK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    logic        is_load;
    logic        is_store;
    logic        is_word;
    logic        ld_misalign;
    logic        st_misalign;
    logic        in_dm;
    logic        in_tmr;
    logic        in_tmr_cnt;
    logic        in_int;
    logic        range_bad;
    logic [4:0]  exc_code;
    logic [31:0] alu_safe;

    assign is_load  = (E_MemOp >= OP_LW) && (E_MemOp <= OP_LBU);
    assign is_store = (E_MemOp >= OP_SW) && (E_MemOp <= OP_SB);
    assign is_word  = (E_MemOp == OP_LW) || (E_MemOp == OP_SW);

    assign ld_misalign = ((E_MemOp == OP_LW) && (E_ALURes[1:0] != 2'b00)) ||
                         (((E_MemOp == OP_LH) || (E_MemOp == OP_LHU)) && E_ALURes[0]);
    assign st_misalign = ((E_MemOp == OP_SW) && (E_ALURes[1:0] != 2'b00)) ||
                         ((E_MemOp == OP_SH) && E_ALURes[0]);

    // Address map decode; only consulted when RANGE_CHK is set, otherwise it is pruned away.
    assign in_dm      = E_ALURes <= DM_END;
    assign in_tmr     = ((E_ALURes >= 32'h0000_7F00) && (E_ALURes <= 32'h0000_7F0B)) ||
                        ((E_ALURes >= 32'h0000_7F10) && (E_ALURes <= 32'h0000_7F1B));
    assign in_tmr_cnt = ((E_ALURes >= 32'h0000_7F08) && (E_ALURes <= 32'h0000_7F0B)) ||
                        ((E_ALURes >= 32'h0000_7F18) && (E_ALURes <= 32'h0000_7F1B));
    assign in_int     = (E_ALURes >= 32'h0000_7F20) && (E_ALURes <= 32'h0000_7F23);
    assign range_bad  = (is_load || is_store) &&
                        (!(in_dm || in_tmr || in_int) ||
                         (in_tmr && !is_word) ||
                         (is_store && in_tmr_cnt));

    always_comb begin
        exc_code = 5'd0;
        if (E_ExcCode != 5'd0) begin
            exc_code = E_ExcCode;
        end else if (E_OvCheck && E_Overflow) begin
            exc_code = EXC_OV;
        end else if (E_Overflow) begin
            if (is_load)
                exc_code = EXC_ADEL;
            else if (is_store)
                exc_code = EXC_ADES;
        end else if (ld_misalign) begin
            exc_code = EXC_ADEL;
        end else if (st_misalign) begin
            exc_code = EXC_ADES;
        end else if (RANGE_CHK && range_bad) begin
            exc_code = is_load ? EXC_ADEL : EXC_ADES;
        end
    end

    // ALU result may float when overflow is flagged; never let that reach the register.
    assign alu_safe = E_Overflow ? 32'd0 : E_ALURes;

    always_ff @(posedge clk) begin
        if (reset) begin
            M_PC        <= RESET_PC;
            M_Instr     <= 32'd0;
            M_ALURes    <= 32'd0;
            M_WriteData <= 32'd0;
            M_RegAddr   <= 5'd0;
            M_BD        <= 1'b0;
            M_MemOp     <= 4'd0;
            M_ExcCode   <= 5'd0;
        end else if (Req) begin
            M_PC        <= EXC_ENTRY;
            M_Instr     <= 32'd0;
            M_ALURes    <= 32'd0;
            M_WriteData <= 32'd0;
            M_RegAddr   <= 5'd0;
            M_BD        <= 1'b0;
            M_MemOp     <= 4'd0;
            M_ExcCode   <= 5'd0;
        end else if (flush) begin
            M_PC        <= E_PC;
            M_Instr     <= 32'd0;
            M_ALURes    <= 32'd0;
            M_WriteData <= 32'd0;
            M_RegAddr   <= 5'd0;
            M_BD        <= E_BD;
            M_MemOp     <= 4'd0;
            M_ExcCode   <= 5'd0;
        end else if (en) begin
            M_PC        <= E_PC;
            M_Instr     <= E_Instr;
            M_ALURes    <= alu_safe;
            M_WriteData <= E_WriteData;
            M_RegAddr   <= (exc_code != 5'd0) ? 5'd0 : E_RegAddr;
            M_BD        <= E_BD;
            M_MemOp     <= (exc_code != 5'd0) ? 4'd0 : E_MemOp;
            M_ExcCode   <= exc_code;
        end
    end

endmodule

// File: tb/tb_em_pipe_reg.sv
// Directed self-checking bench for em_pipe_reg; range-check scenarios run only when EM_ADDR_RANGE_CHK_EN is defined.
`timescale 1ns/1ps
module tb_em_pipe_reg;

    logic        clk;
    logic        reset;
    logic        en;
    logic        flush;
    logic        Req;
    logic [31:0] E_PC;
    logic [31:0] E_Instr;
    logic [31:0] E_ALURes;
    logic        E_Overflow;
    logic [31:0] E_WriteData;
    logic [4:0]  E_RegAddr;
    logic        E_BD;
    logic [4:0]  E_ExcCode;
    logic        E_OvCheck;
    logic [3:0]  E_MemOp;
    logic [31:0] M_PC;
    logic [31:0] M_Instr;
    logic [31:0] M_ALURes;
    logic [31:0] M_WriteData;
    logic [4:0]  M_RegAddr;
    logic        M_BD;
    logic [3:0]  M_MemOp;
    logic [4:0]  M_ExcCode;

    int checks = 0;
    int errors = 0;

    em_pipe_reg dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .Req(Req),
        .E_PC(E_PC), .E_Instr(E_Instr), .E_ALURes(E_ALURes), .E_Overflow(E_Overflow),
        .E_WriteData(E_WriteData), .E_RegAddr(E_RegAddr), .E_BD(E_BD),
        .E_ExcCode(E_ExcCode), .E_OvCheck(E_OvCheck), .E_MemOp(E_MemOp),
        .M_PC(M_PC), .M_Instr(M_Instr), .M_ALURes(M_ALURes), .M_WriteData(M_WriteData),
        .M_RegAddr(M_RegAddr), .M_BD(M_BD), .M_MemOp(M_MemOp), .M_ExcCode(M_ExcCode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] alu,
                         input logic ov, input logic [31:0] wd, input logic [4:0] ra,
                         input logic bd, input logic [4:0] exc, input logic ovchk,
                         input logic [3:0] memop);
        E_PC = pc; E_Instr = instr; E_ALURes = alu; E_Overflow = ov; E_WriteData = wd;
        E_RegAddr = ra; E_BD = bd; E_ExcCode = exc; E_OvCheck = ovchk; E_MemOp = memop;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; flush = 1'b0; Req = 1'b0;
        drive(32'h1234_5678, 32'hFFFF_FFFF, 32'h55, 1'b0, 32'hAA, 5'd7, 1'b1, 5'd0, 1'b0, 4'd1);
        tick(); tick();
        checks++;
        if (M_PC !== 32'h0000_3000) begin errors++; $display("FAIL reset_pc: got %h expected %h", M_PC, 32'h0000_3000); end
        checks++;
        if ({M_Instr, M_ALURes, M_WriteData} !== 96'd0) begin errors++;
            $display("FAIL reset_data: got instr=%h alu=%h wd=%h expected all 0", M_Instr, M_ALURes, M_WriteData); end
        checks++;
        if ({M_RegAddr, M_BD, M_MemOp, M_ExcCode} !== 15'd0) begin errors++;
            $display("FAIL reset_ctrl: got ra=%0d bd=%0d op=%0d exc=%0d expected all 0", M_RegAddr, M_BD, M_MemOp, M_ExcCode); end
        reset = 1'b0;
    endtask

    task automatic test_load();
        drive(32'h0000_3000, 32'h8C88_0104, 32'h0000_0104, 1'b0, 32'hDEAD_BEEF, 5'd8, 1'b0, 5'd0, 1'b0, 4'd1);
        #1;
        checks++;
        if (M_ALURes !== 32'd0) begin errors++; $display("FAIL load_latency: got %h expected %h before edge", M_ALURes, 32'd0); end
        tick();
        checks++;
        if (M_ALURes !== 32'h104) begin errors++; $display("FAIL load_alures: got %h expected %h", M_ALURes, 32'h104); end
        checks++;
        if (M_ExcCode !== 5'd0) begin errors++; $display("FAIL load_exc: got %0d expected 0", M_ExcCode); end
        checks++;
        if (M_RegAddr !== 5'd8 || M_MemOp !== 4'd1) begin errors++;
            $display("FAIL load_ctrl: got ra=%0d op=%0d expected ra=8 op=1", M_RegAddr, M_MemOp); end
        checks++;
        if (M_PC !== 32'h3000 || M_Instr !== 32'h8C88_0104 || M_WriteData !== 32'hDEAD_BEEF) begin errors++;
            $display("FAIL load_copy: got pc=%h instr=%h wd=%h", M_PC, M_Instr, M_WriteData); end
    endtask

    task automatic test_overflow();
        drive(32'h0000_3004, 32'h00A6_3020, 32'hzzzz_zzzz, 1'b1, 32'h0, 5'd8, 1'b0, 5'd0, 1'b1, 4'd0);
        tick();
        checks++;
        if (M_ExcCode !== 5'd12) begin errors++; $display("FAIL ov_exc: got %0d expected 12", M_ExcCode); end
        checks++;
        if (M_ALURes !== 32'd0) begin errors++; $display("FAIL ov_alures: got %h expected 0", M_ALURes); end
        checks++;
        if (M_RegAddr !== 5'd0) begin errors++; $display("FAIL ov_regaddr: got %0d expected 0", M_RegAddr); end
        // addiu-style overflow: no trap, result zeroed, destination kept
        drive(32'h0000_3008, 32'h2508_0001, 32'hzzzz_zzzz, 1'b1, 32'h0, 5'd9, 1'b0, 5'd0, 1'b0, 4'd0);
        tick();
        checks++;
        if (M_ExcCode !== 5'd0 || M_ALURes !== 32'd0 || M_RegAddr !== 5'd9) begin errors++;
            $display("FAIL addiu_ov: got exc=%0d alu=%h ra=%0d expected exc=0 alu=0 ra=9", M_ExcCode, M_ALURes, M_RegAddr); end
        // memory op whose address computation overflowed
        drive(32'h0000_300C, 32'h8C00_0000, 32'hzzzz_zzzz, 1'b1, 32'h0, 5'd4, 1'b0, 5'd0, 1'b0, 4'd3);
        tick();
        checks++;
        if (M_ExcCode !== 5'd4 || M_MemOp !== 4'd0) begin errors++;
            $display("FAIL ov_load: got exc=%0d op=%0d expected exc=4 op=0", M_ExcCode, M_MemOp); end
        drive(32'h0000_3010, 32'hAC00_0000, 32'hzzzz_zzzz, 1'b1, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 4'd8);
        tick();
        checks++;
        if (M_ExcCode !== 5'd5 || M_MemOp !== 4'd0) begin errors++;
            $display("FAIL ov_store: got exc=%0d op=%0d expected exc=5 op=0", M_ExcCode, M_MemOp); end
    endtask

    task automatic test_misaligned();
        drive(32'h0000_3014, 32'hA400_0003, 32'h0000_0003, 1'b0, 32'h1111, 5'd0, 1'b0, 5'd0, 1'b0, 4'd7);
        tick();
        checks++;
        if (M_ExcCode !== 5'd5 || M_MemOp !== 4'd0) begin errors++;
            $display("FAIL sh_misalign: got exc=%0d op=%0d expected exc=5 op=0", M_ExcCode, M_MemOp); end
        drive(32'h0000_3018, 32'hA000_0003, 32'h0000_0003, 1'b0, 32'h1111, 5'd0, 1'b0, 5'd0, 1'b0, 4'd8);
        tick();
        checks++;
        if (M_ExcCode !== 5'd0 || M_MemOp !== 4'd8 || M_ALURes !== 32'h3) begin errors++;
            $display("FAIL sb_aligned: got exc=%0d op=%0d alu=%h expected exc=0 op=8 alu=3", M_ExcCode, M_MemOp, M_ALURes); end
        drive(32'h0000_301C, 32'h8C00_0102, 32'h0000_0102, 1'b0, 32'h0, 5'd6, 1'b0, 5'd0, 1'b0, 4'd1);
        tick();
        checks++;
        if (M_ExcCode !== 5'd4 || M_RegAddr !== 5'd0) begin errors++;
            $display("FAIL lw_misalign: got exc=%0d ra=%0d expected exc=4 ra=0", M_ExcCode, M_RegAddr); end
        drive(32'h0000_3020, 32'h9400_0101, 32'h0000_0101, 1'b0, 32'h0, 5'd6, 1'b0, 5'd0, 1'b0, 4'd3);
        tick();
        checks++;
        if (M_ExcCode !== 5'd4) begin errors++; $display("FAIL lhu_misalign: got %0d expected 4", M_ExcCode); end
        drive(32'h0000_3024, 32'h8400_0102, 32'h0000_0102, 1'b0, 32'h0, 5'd6, 1'b0, 5'd0, 1'b0, 4'd2);
        tick();
        checks++;
        if (M_ExcCode !== 5'd0 || M_RegAddr !== 5'd6 || M_MemOp !== 4'd2) begin errors++;
            $display("FAIL lh_aligned: got exc=%0d ra=%0d op=%0d expected 0/6/2", M_ExcCode, M_RegAddr, M_MemOp); end
        drive(32'h0000_3028, 32'hAC00_0002, 32'h0000_0002, 1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 4'd6);
        tick();
        checks++;
        if (M_ExcCode !== 5'd5) begin errors++; $display("FAIL sw_misalign: got %0d expected 5", M_ExcCode); end
    endtask

    task automatic test_passthrough();
        drive(32'h0000_302C, 32'h0000_000C, 32'hzzzz_zzzz, 1'b1, 32'h0, 5'd3, 1'b1, 5'd10, 1'b1, 4'd1);
        tick();
        checks++;
        if (M_ExcCode !== 5'd10 || M_RegAddr !== 5'd0 || M_MemOp !== 4'd0 || M_BD !== 1'b1) begin errors++;
            $display("FAIL passthrough: got exc=%0d ra=%0d op=%0d bd=%0d expected 10/0/0/1", M_ExcCode, M_RegAddr, M_MemOp, M_BD); end
    endtask

    task automatic test_stall_flush();
        drive(32'h0000_3008, 32'h8C43_0200, 32'h0000_0200, 1'b0, 32'hCAFE, 5'd3, 1'b0, 5'd0, 1'b0, 4'd1);
        tick();
        en = 1'b0;
        drive(32'h0000_300C, 32'h1234_0000, 32'h0000_0999, 1'b0, 32'hBEEF, 5'd12, 1'b1, 5'd0, 1'b0, 4'd6);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (M_PC !== 32'h3008 || M_ALURes !== 32'h200 || M_RegAddr !== 5'd3 || M_MemOp !== 4'd1 || M_WriteData !== 32'hCAFE) begin
                errors++;
                $display("FAIL stall_hold%0d: got pc=%h alu=%h ra=%0d op=%0d wd=%h expected 3008/200/3/1/cafe",
                         i, M_PC, M_ALURes, M_RegAddr, M_MemOp, M_WriteData);
            end
        end
        flush = 1'b1;
        drive(32'h0000_3010, 32'h8C44_0300, 32'h0000_0300, 1'b0, 32'h7777, 5'd4, 1'b1, 5'd0, 1'b0, 4'd1);
        tick();
        checks++;
        if (M_Instr !== 32'd0 || M_PC !== 32'h3010 || M_BD !== 1'b1) begin errors++;
            $display("FAIL flush_bubble: got instr=%h pc=%h bd=%0d expected 0/3010/1", M_Instr, M_PC, M_BD); end
        checks++;
        if ({M_ALURes, M_WriteData, M_RegAddr, M_MemOp, M_ExcCode} !== 78'd0) begin errors++;
            $display("FAIL flush_clear: got alu=%h wd=%h ra=%0d op=%0d exc=%0d expected all 0",
                     M_ALURes, M_WriteData, M_RegAddr, M_MemOp, M_ExcCode); end
        flush = 1'b0; en = 1'b1;
    endtask

    task automatic test_req();
        drive(32'h0000_3030, 32'h8C45_0010, 32'h0000_0010, 1'b0, 32'h4444, 5'd5, 1'b1, 5'd0, 1'b0, 4'd1);
        tick();
        Req = 1'b1; flush = 1'b1;
        tick();
        checks++;
        if (M_PC !== 32'h0000_4180) begin errors++; $display("FAIL req_pc: got %h expected %h", M_PC, 32'h0000_4180); end
        checks++;
        if ({M_Instr, M_ALURes, M_WriteData, M_RegAddr, M_BD, M_MemOp, M_ExcCode} !== 111'd0) begin errors++;
            $display("FAIL req_clear: got instr=%h alu=%h wd=%h ra=%0d bd=%0d op=%0d exc=%0d expected all 0",
                     M_Instr, M_ALURes, M_WriteData, M_RegAddr, M_BD, M_MemOp, M_ExcCode); end
        Req = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        drive(32'h0000_3040, 32'h8C46_0020, 32'h0000_0020, 1'b0, 32'h5555, 5'd6, 1'b1, 5'd0, 1'b0, 4'd1);
        tick();
        en = 1'b0; reset = 1'b1;
        tick();
        checks++;
        if (M_PC !== 32'h3000 || M_ALURes !== 32'd0 || M_RegAddr !== 5'd0 || M_BD !== 1'b0) begin errors++;
            $display("FAIL reset_stall: got pc=%h alu=%h ra=%0d bd=%0d expected 3000/0/0/0", M_PC, M_ALURes, M_RegAddr, M_BD); end
        reset = 1'b0; en = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [3:0]  ops   [3];
        logic [4:0]  excs  [3];
        addrs = '{32'h0000_0010, 32'h0000_0011, 32'h0000_0012};
        ops   = '{4'd1, 4'd5, 4'd7};
        excs  = '{5'd0, 5'd0, 5'd0};
        for (int i = 0; i < 3; i++) begin
            drive(32'h0000_3100 + 32'(i * 4), 32'h0, addrs[i], 1'b0, 32'h0, 5'd1, 1'b0, 5'd0, 1'b0, ops[i]);
            tick();
            checks++;
            if (M_ALURes !== addrs[i] || M_MemOp !== ops[i] || M_ExcCode !== excs[i] || M_PC !== 32'h0000_3100 + 32'(i * 4)) begin
                errors++;
                $display("FAIL b2b%0d: got alu=%h op=%0d exc=%0d pc=%h expected alu=%h op=%0d exc=%0d",
                         i, M_ALURes, M_MemOp, M_ExcCode, M_PC, addrs[i], ops[i], excs[i]);
            end
        end
    endtask

`ifdef EM_ADDR_RANGE_CHK_EN
    task automatic test_range();
        logic [31:0] addrs [6];
        logic [3:0]  ops   [6];
        logic [4:0]  excs  [6];
        addrs = '{32'h0000_7F08, 32'h0000_7F08, 32'h0000_3000, 32'h0000_7F00, 32'h0000_7F20, 32'h0000_2FFC};
        ops   = '{4'd1,          4'd6,          4'd1,          4'd4,          4'd6,          4'd6};
        excs  = '{5'd0,          5'd5,          5'd4,          5'd4,          5'd0,          5'd0};
        for (int i = 0; i < 6; i++) begin
            drive(32'h0000_3200, 32'h0, addrs[i], 1'b0, 32'h0, 5'd2, 1'b0, 5'd0, 1'b0, ops[i]);
            tick();
            checks++;
            if (M_ExcCode !== excs[i]) begin errors++;
                $display("FAIL range%0d: addr=%h op=%0d got exc=%0d expected %0d", i, addrs[i], ops[i], M_ExcCode, excs[i]); end
        end
    endtask
`endif

    initial begin
        reset = 1'b1; en = 1'b1; flush = 1'b0; Req = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 4'd0);
        test_reset();
        test_load();
        test_overflow();
        test_misaligned();
        test_passthrough();
        test_stall_flush();
        test_req();
        test_reset_mid_stall();
        test_back_to_back();
`ifdef EM_ADDR_RANGE_CHK_EN
        test_range();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
